// File: rtl/rgb_compositor.sv
// rgb_compositor
//   Two-stage pixel compositor that sits between the layer pixel generators
//   and the video output register.
//   Stage 1 picks a colour from the layers using the committed game state.
//   Stage 2 scales that colour by the current fade level.
//   A small FSM fades the picture out and back in whenever the game state
//   changes. Each step of the fade is one frame_start_i pulse.
//
// Optional build macro: RGB_COMPOSITOR_COLOR_KEY_EN
//   When defined, this adds the KEY_COLOR parameter and the key_enable_i port.
//   A keyed priority layer whose pixel equals KEY_COLOR is treated as
//   transparent.
//
// Ports
//   clk_i             clock
//   rst_i             synchronous active-high reset
//   display_enable_i  active video for the current pixel
//   frame_start_i     one-cycle pulse per frame (fade step)
//   state_i           game state: 0 menu, 1 playing, 2 continue, 3 final
//   map_enable_i      pixel lies inside the map area (OR-blend region)
//   layer_enable_i    per-layer pixel-valid
//   layer_rgb_i       layer k at [k*COLOR_BITS +: COLOR_BITS], {blue,green,red}
//   key_enable_i      per-layer colour-key enable (macro builds only)
//   blue_o/green_o/red_o  composited colour, 2 cycles after the inputs
//   de_o              display_enable_i aligned with the colour outputs
//   fade_busy_o       high while a fade is in progress
//
// Fade FSM
//   state    | meaning
//   IDLE     | level full, waiting for state_i to differ from committed state
//   FADE_OUT | level steps down per frame; commits state_i when it hits 0
//   FADE_IN  | level steps up per frame; returns to IDLE at full level

module rgb_compositor #(
  parameter int                       COLOR_BITS = 24,
  parameter int                       NUM_LAYERS = 5,
  parameter logic [NUM_LAYERS-1:0]    OR_MASK    = 5'b00111,
  parameter logic [COLOR_BITS-1:0]    BG_COLOR   = 24'hE0E0E0,
  parameter int                       FADE_LOG2  = 4
`ifdef RGB_COMPOSITOR_COLOR_KEY_EN
  ,
  parameter logic [COLOR_BITS-1:0]    KEY_COLOR  = 24'hFF00FF
`endif
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             display_enable_i,
  input  logic                             frame_start_i,
  input  logic [1:0]                       state_i,
  input  logic                             map_enable_i,
  input  logic [NUM_LAYERS-1:0]            layer_enable_i,
  input  logic [NUM_LAYERS*COLOR_BITS-1:0] layer_rgb_i,
`ifdef RGB_COMPOSITOR_COLOR_KEY_EN
  input  logic [NUM_LAYERS-1:0]            key_enable_i,
`endif
  output logic [COLOR_BITS/3-1:0]          blue_o,
  output logic [COLOR_BITS/3-1:0]          green_o,
  output logic [COLOR_BITS/3-1:0]          red_o,
  output logic                             de_o,
  output logic                             fade_busy_o
);

  localparam int CW = COLOR_BITS / 3;
  localparam int LW = FADE_LOG2 + 1;
  // Product width: a CW-bit channel times a level of at most 2^FADE_LOG2.
  localparam int PW = CW + FADE_LOG2 + 1;
  localparam logic [LW-1:0] LEVEL_FULL = LW'(2 ** FADE_LOG2);
  localparam logic [LW-1:0] LEVEL_ONE  = LW'(1);
  localparam logic [1:0]    ST_PLAYING = 2'd1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FADE_OUT = 2'd1,
    FADE_IN  = 2'd2
  } fade_state_t;

  fade_state_t fade_q, fade_d;
  logic [LW-1:0] level_q, level_d;
  logic [1:0]    committed_q, committed_d;

  // ------------------------------------------------------------------
  // Fade FSM
  // ------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fade_q      <= IDLE;
      level_q     <= LEVEL_FULL;
      committed_q <= 2'd0;
    end else begin
      fade_q      <= fade_d;
      level_q     <= level_d;
      committed_q <= committed_d;
    end
  end

  always_comb begin
    fade_d      = fade_q;
    level_d     = level_q;
    committed_d = committed_q;
    case (fade_q)
      IDLE: begin
        // A frame pulse arriving together with the state change is not a step.
        if (state_i != committed_q) fade_d = FADE_OUT;
      end
      FADE_OUT: begin
        if (frame_start_i) begin
          // A fade reversed at level 0 must still commit on its next pulse,
          // so treat level 0 the same as level 1 here.
          if (level_q <= LEVEL_ONE) begin
            level_d     = '0;
            committed_d = state_i;
            fade_d      = FADE_IN;
          end else begin
            level_d = level_q - LEVEL_ONE;
          end
        end
      end
      FADE_IN: begin
        // A new state request takes priority over a coincident frame step.
        if (state_i != committed_q) begin
          fade_d = FADE_OUT;
        end else if (frame_start_i) begin
          if (level_q >= LEVEL_FULL - LEVEL_ONE) begin
            level_d = LEVEL_FULL;
            fade_d  = IDLE;
          end else begin
            level_d = level_q + LEVEL_ONE;
          end
        end
      end
      default: fade_d = IDLE;
    endcase
  end

  assign fade_busy_o = (fade_q != IDLE);

  // ------------------------------------------------------------------
  // Stage 1: layer selection
  // ------------------------------------------------------------------
  logic [NUM_LAYERS-1:0] key_hit;

`ifdef RGB_COMPOSITOR_COLOR_KEY_EN
  always_comb begin
    key_hit = '0;
    for (int k = 0; k < NUM_LAYERS; k++) begin
      key_hit[k] = key_enable_i[k] &&
                   (layer_rgb_i[k*COLOR_BITS +: COLOR_BITS] == KEY_COLOR);
    end
  end
`else
  assign key_hit = '0;
`endif

  logic [COLOR_BITS-1:0] layer_px;
  logic [COLOR_BITS-1:0] blend_color;
  logic [COLOR_BITS-1:0] prio_color;
  logic [COLOR_BITS-1:0] sel_color;

  always_comb begin
    layer_px    = '0;
    blend_color = '0;
    prio_color  = BG_COLOR;
    // Walk from the lowest priority upward so the lowest index wins.
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      layer_px = layer_rgb_i[k*COLOR_BITS +: COLOR_BITS];
      if (OR_MASK[k] && layer_enable_i[k]) blend_color = blend_color | layer_px;
      if (!OR_MASK[k] && layer_enable_i[k] && !key_hit[k]) prio_color = layer_px;
    end
  end

  always_comb begin
    sel_color = '0;
    if (!display_enable_i)             sel_color = '0;
    else if (committed_q != ST_PLAYING) sel_color = BG_COLOR;
    else if (map_enable_i)             sel_color = blend_color;
    else                               sel_color = prio_color;
  end

  logic [COLOR_BITS-1:0] s1_color;
  logic                  s1_de;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_color <= '0;
      s1_de    <= 1'b0;
    end else begin
      s1_color <= sel_color;
      s1_de    <= display_enable_i;
    end
  end

  // ------------------------------------------------------------------
  // Stage 2: fade scaling, channel c at s1_color[c*CW +: CW]
  // (0 red, 1 green, 2 blue)
  // ------------------------------------------------------------------
  logic [2:0][PW-1:0] prod;
  logic [2:0][CW-1:0] scaled;

  always_comb begin
    prod   = '0;
    scaled = '0;
    for (int c = 0; c < 3; c++) begin
      prod[c]   = PW'(s1_color[c*CW +: CW]) * PW'(level_q);
      scaled[c] = CW'(prod[c] >> FADE_LOG2);
    end
  end

  logic [2:0][CW-1:0] out_color;
  logic               out_de;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_color <= '0;
      out_de    <= 1'b0;
    end else begin
      out_color <= s1_de ? scaled : '0;
      out_de    <= s1_de;
    end
  end

  assign red_o   = out_color[0];
  assign green_o = out_color[1];
  assign blue_o  = out_color[2];
  assign de_o    = out_de;

endmodule

// File: tb/tb_rgb_compositor.sv
module tb_rgb_compositor;

  localparam int NL = 5;
  localparam int CB = 24;
  localparam logic [NL-1:0] OR_MASK = 5'b00111;
  localparam logic [23:0] BG = 24'hE0E0E0;
  localparam logic [23:0] KEY = 24'hFF00FF;
  localparam int FULL = 16;
  localparam logic [NL*CB-1:0] LAYERS =
    {24'h00FF00, 24'h0000FF, 24'h800000, 24'h008000, 24'h000080};
  localparam logic [NL*CB-1:0] KLAYERS =
    {24'h00FF00, 24'hFF00FF, 24'h800000, 24'h008000, 24'h000080};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic de = 1'b0;
  logic fs = 1'b0;
  logic [1:0] st = 2'd0;
  logic map_en = 1'b0;
  logic [NL-1:0] en = '0;
  logic [NL-1:0] key_en = '0;
  logic [NL*CB-1:0] rgb = '0;
  logic [7:0] blue, green, red;
  logic de_out, busy;

  int total = 0;
  int bad = 0;

  // reference model state
  int m_level = FULL;
  int m_comm = 0;
  int m_mode = 0;  // 0 steady, 1 dimming, 2 brightening
  logic [23:0] p1_col = '0, p2_col = '0;
  logic p1_de = 1'b0, p2_de = 1'b0, m_busy = 1'b0;

  always #5 clk = ~clk;

  rgb_compositor dut (
    .clk_i(clk),
    .rst_i(rst),
    .display_enable_i(de),
    .frame_start_i(fs),
    .state_i(st),
    .map_enable_i(map_en),
    .layer_enable_i(en),
    .layer_rgb_i(rgb),
`ifdef RGB_COMPOSITOR_COLOR_KEY_EN
    .key_enable_i(key_en),
`endif
    .blue_o(blue),
    .green_o(green),
    .red_o(red),
    .de_o(de_out),
    .fade_busy_o(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] m_select(input logic d, input logic m, input logic [NL-1:0] e,
                                           input logic [NL-1:0] ke, input logic [NL*CB-1:0] px,
                                           input int comm);
    logic [23:0] acc;
    bit keyed;
    if (!d) return 24'h0;
    if (comm != 1) return BG;
    if (m) begin
      acc = '0;
      for (int k = 0; k < NL; k++)
        if (OR_MASK[k] && e[k]) acc = acc | px[k*CB +: CB];
      return acc;
    end
    for (int k = 0; k < NL; k++) begin
`ifdef RGB_COMPOSITOR_COLOR_KEY_EN
      keyed = ke[k] && (px[k*CB +: CB] == KEY);
`else
      keyed = ke[k] && 1'b0;
`endif
      if (!OR_MASK[k] && e[k] && !keyed) return px[k*CB +: CB];
    end
    return BG;
  endfunction

  function automatic logic [23:0] m_scale(input logic [23:0] c, input int lvl);
    logic [23:0] r;
    for (int ch = 0; ch < 3; ch++) r[ch*8 +: 8] = 8'((int'(c[ch*8 +: 8]) * lvl) / FULL);
    return r;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_step();
    if (rst) begin
      m_level = FULL; m_comm = 0; m_mode = 0;
      p1_col = '0; p1_de = 0; p2_col = '0; p2_de = 0;
    end else begin
      p2_de  = p1_de;
      p2_col = p1_de ? m_scale(p1_col, m_level) : 24'h0;
      p1_de  = de;
      p1_col = m_select(de, map_en, en, key_en, rgb, m_comm);
      if (m_mode == 0) begin
        if (int'(st) != m_comm) m_mode = 1;
      end else if (m_mode == 1) begin
        if (fs) begin
          m_level = (m_level > 0) ? m_level - 1 : 0;
          if (m_level == 0) begin m_comm = int'(st); m_mode = 2; end
        end
      end else begin
        if (int'(st) != m_comm) m_mode = 1;
        else if (fs) begin
          m_level = (m_level < FULL) ? m_level + 1 : FULL;
          if (m_level == FULL) m_mode = 0;
        end
      end
    end
    m_busy = (m_mode != 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model", {6'd0, de_out, busy, blue, green, red}, {6'd0, p2_de, m_busy, p2_col});
  endtask

  task automatic pulse(input int gap);
    fs = 1'b1;
    cycle();
    fs = 1'b0;
    repeat (gap) cycle();
  endtask

  function automatic logic [31:0] outv();
    return {7'd0, de_out, blue, green, red};
  endfunction

  typedef struct {
    int phase;  // 0: menu committed, 1: playing committed
    logic d;
    logic m;
    logic [NL-1:0] e;
    logic [NL-1:0] ke;
    logic [NL*CB-1:0] px;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[14];

  initial begin
    vecs[0]  = '{0, 1'b1, 1'b1, 5'b11111, 5'b00000, LAYERS, 24'hE0E0E0};
    vecs[1]  = '{0, 1'b1, 1'b0, 5'b11111, 5'b00000, LAYERS, 24'hE0E0E0};
    vecs[2]  = '{0, 1'b0, 1'b1, 5'b11111, 5'b00000, LAYERS, 24'h000000};
    vecs[3]  = '{1, 1'b1, 1'b1, 5'b11111, 5'b00000, LAYERS, 24'h808080};
    vecs[4]  = '{1, 1'b1, 1'b0, 5'b11111, 5'b00000, LAYERS, 24'h0000FF};
    vecs[5]  = '{1, 1'b1, 1'b0, 5'b00111, 5'b00000, LAYERS, 24'hE0E0E0};
    vecs[6]  = '{1, 1'b1, 1'b0, 5'b10111, 5'b00000, LAYERS, 24'h00FF00};
    vecs[7]  = '{1, 1'b1, 1'b1, 5'b00000, 5'b00000, LAYERS, 24'h000000};
    vecs[8]  = '{1, 1'b1, 1'b1, 5'b00101, 5'b00000, LAYERS, 24'h800080};
    vecs[9]  = '{1, 1'b0, 1'b1, 5'b11111, 5'b00000, LAYERS, 24'h000000};
    vecs[10] = '{1, 1'b1, 1'b1, 5'b11000, 5'b00000, LAYERS, 24'h000000};
    vecs[11] = '{1, 1'b1, 1'b0, 5'b11000, 5'b00000, KLAYERS, 24'hFF00FF};
`ifdef RGB_COMPOSITOR_COLOR_KEY_EN
    vecs[12] = '{1, 1'b1, 1'b0, 5'b11000, 5'b01000, KLAYERS, 24'h00FF00};
    vecs[13] = '{1, 1'b1, 1'b0, 5'b01000, 5'b01000, KLAYERS, 24'hE0E0E0};
`else
    vecs[12] = '{1, 1'b1, 1'b0, 5'b11000, 5'b01000, KLAYERS, 24'hFF00FF};
    vecs[13] = '{1, 1'b1, 1'b0, 5'b01000, 5'b01000, KLAYERS, 24'hFF00FF};
`endif

    // reset
    rst = 1'b1;
    repeat (3) cycle();
    chk("reset_out", {7'd0, de_out, busy, blue, green, red}, 32'd0);
    rst = 1'b0;
    de = 1'b1;
    st = 2'd0;
    cycle();
    chk("first_cycle_zero", outv(), 32'h0);
    cycle();
    chk("menu_bg", outv(), {7'd0, 1'b1, 24'hE0E0E0});
    repeat (8) cycle();
    chk("menu_not_busy", {31'd0, busy}, 32'd0);

    // menu-phase vectors
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].phase == 0) begin
        de = vecs[i].d; map_en = vecs[i].m; en = vecs[i].e;
        key_en = vecs[i].ke; rgb = vecs[i].px;
        cycle(); cycle();
        chk($sformatf("vec%0d", i), outv(), {7'd0, vecs[i].d, vecs[i].exp});
      end
    end

    // fade 0 -> 1: map off, number layer enabled so the committed state is visible
    de = 1'b1; map_en = 1'b0; en = 5'b10111; key_en = '0; rgb = LAYERS;
    cycle(); cycle();
    st = 2'd1;
    cycle();
    chk("busy_rise", {31'd0, busy}, 32'd1);
    repeat (8) pulse(99);
    chk("level8_bg", outv(), {7'd0, 1'b1, 24'h707070});
    repeat (8) pulse(99);
    chk("level0_black", outv(), {7'd0, 1'b1, 24'h000000});
    pulse(99);
    chk("level1_playing", outv(), {7'd0, 1'b1, 24'h000F00});
    repeat (15) pulse(99);
    chk("fade_done_idle", {31'd0, busy}, 32'd0);
    chk("fade_done_pass", outv(), {7'd0, 1'b1, 24'h00FF00});

    // playing-phase vectors
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].phase == 1) begin
        de = vecs[i].d; map_en = vecs[i].m; en = vecs[i].e;
        key_en = vecs[i].ke; rgb = vecs[i].px;
        cycle(); cycle();
        chk($sformatf("vec%0d", i), outv(), {7'd0, vecs[i].d, vecs[i].exp});
      end
    end

    // fade 1 -> 3, reverse during fade-in at level 10
    de = 1'b1; map_en = 1'b0; en = 5'b00111; key_en = '0; rgb = LAYERS;
    st = 2'd3;
    cycle(); cycle();
    repeat (16) pulse(20);
    repeat (10) pulse(20);
    chk("fadein_level10", outv(), {7'd0, 1'b1, 24'h8C8C8C});
    st = 2'd1;
    cycle();
    chk("reverse_busy", {31'd0, busy}, 32'd1);
    pulse(20);
    chk("reverse_level9", outv(), {7'd0, 1'b1, 24'h7E7E7E});

    // reset mid-fade
    en = 5'b10111;
    rst = 1'b1;
    st = 2'd0;
    cycle();
    chk("midfade_reset", {7'd0, de_out, busy, blue, green, red}, 32'd0);
    rst = 1'b0;
    cycle();
    chk("post_reset_zero", outv(), 32'h0);
    cycle();
    chk("post_reset_menu_full", outv(), {7'd0, 1'b1, 24'hE0E0E0});
    chk("post_reset_idle", {31'd0, busy}, 32'd0);

    // randomized traffic against the model
    for (int n = 0; n < 5000; n++) begin
      de = ($urandom_range(0, 7) != 0);
      map_en = $urandom_range(0, 1) == 1;
      en = NL'($urandom);
      key_en = NL'($urandom);
      for (int k = 0; k < NL; k++)
        rgb[k*CB +: CB] = ($urandom_range(0, 3) == 0) ? KEY : 24'($urandom);
      fs = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 199) == 0) st = 2'($urandom);
      rst = ($urandom_range(0, 1499) == 0);
      cycle();
    end
    rst = 1'b0;
    fs = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_compositor.md
Name: rgb_compositor

Overview:
- Parametrised, pipelined successor to the per-pixel RGB render mux.
- Composites NUM_LAYERS sprite/tile layers by priority, with per-layer OR-blend inside the map region.
- Replaces per-state flags with an encoded game state and adds a frame-timed fade-out/fade-in between game states.
- Sits between the layer pixel generators and the VGA/HDMI output register.

Parameters:
- COLOR_BITS, 24, total bits per pixel; multiple of 3; channel width CW = COLOR_BITS/3.
- NUM_LAYERS, 5, number of input layers (1..8); layer 0 has the highest priority.
- OR_MASK, 5'b00111, bit k=1: layer k is an OR-blend layer (map/player/bullet); 0: priority layer (number/tank).
- BG_COLOR, 24'hE0E0E0, packed {blue,green,red} background colour.
- FADE_LOG2, 4, fade step count = 2^FADE_LOG2 (range 1..6).

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, synchronous active-high reset.
- display_enable_i, input, 1, active video for the current pixel.
- frame_start_i, input, 1, one-cycle pulse per frame.
- state_i, input, 2, game state: 0 menu, 1 playing, 2 continue, 3 final.
- map_enable_i, input, 1, pixel lies inside the map area.
- layer_enable_i, input, NUM_LAYERS, per-layer pixel-valid.
- layer_rgb_i, input, NUM_LAYERS*COLOR_BITS, layer k at bits [k*COLOR_BITS +: COLOR_BITS], packed {blue,green,red}.
- blue_o, green_o, red_o, output, CW each, composited colour.
- de_o, output, 1, display_enable_i delayed to align with the colour outputs.
- fade_busy_o, output, 1, high while the FSM is not IDLE.

Behaviour:
- Reset (rst_i sampled high at a rising edge of clk_i):
  - All colour outputs = 0, de_o = 0, fade_busy_o = 0.
  - Pipeline registers cleared; FSM = IDLE; level = 2^FADE_LOG2 (full); committed_state = 0 (menu).
  - Reset mid-fade abandons the fade immediately.
- Pipeline: 2-cycle latency. Inputs sampled at edge N appear on outputs after edge N+2; de_o follows the same delay. Throughput is one pixel per clock with no stalls.
- Stage 1 (select, uses committed_state, not state_i):
  - display_enable_i = 0: colour = 0.
  - committed_state != 1: colour = BG_COLOR.
  - committed_state = 1 and map_enable_i = 1: colour = bitwise OR of layer_rgb over layers k where OR_MASK[k] and layer_enable_i[k] are both set; 0 if none.
  - committed_state = 1 and map_enable_i = 0: colour = the lowest-index enabled layer with OR_MASK[k] = 0; BG_COLOR if none.
- Stage 2 (scale): per channel out = (c * level) >> FADE_LOG2.
  - Intermediate width is CW+FADE_LOG2+1, unsigned, truncating.
  - level = 2^FADE_LOG2 gives exact passthrough; level = 0 gives black.
  - Colour outputs are forced to 0 when the delayed DE is 0.
- Fade FSM:
  - IDLE: if state_i != committed_state, go to FADE_OUT next cycle. A frame_start_i in that same cycle is not counted.
  - FADE_OUT: each frame_start_i decrements level by 1. On the frame_start_i where level goes 1 -> 0, load committed_state <= state_i (the current value) and go to FADE_IN. If state_i returns to committed_state during FADE_OUT, the fade still completes (out, then in).
  - FADE_IN: each frame_start_i increments level. On reaching 2^FADE_LOG2, go to IDLE. If state_i != committed_state during FADE_IN, go to FADE_OUT and continue from the current level.
  - level saturates at both ends: never below 0, never above 2^FADE_LOG2.
  - level and committed_state change only on edges. They affect pixels entering stage 1/stage 2 from the following cycle onward.
- Full fade duration = 2*2^FADE_LOG2 frame_start_i pulses (32 with defaults).

Optional Feature:
- Macro: RGB_COMPOSITOR_COLOR_KEY_EN.
- When defined:
  - Adds parameter KEY_COLOR (default 24'hFF00FF).
  - Adds input port key_enable_i (NUM_LAYERS bits).
  - A priority layer k with key_enable_i[k] = 1 and layer_rgb == KEY_COLOR is treated as not enabled, so the next enabled layer (or BG_COLOR) shows through.
  - The comparison is done in stage 1; latency is unchanged.
- When undefined: no key logic and no extra port; layer_enable_i alone decides validity.

Test Plan:
- Reset, then state_i = 0, DE = 1 for 10 cycles -> from cycle 2 on, {b,g,r} = E0,E0,E0; de_o high; fade_busy_o = 0. Before that, outputs = 0.
- Playing (committed after fade), map_enable = 1, layer0 = 000080, layer1 = 008000, layer2 = 800000, all enabled -> output {b,g,r} = 80,80,80 two cycles later.
- Playing, map_enable = 0, layers 3 and 4 enabled (tank 0000FF, number 00FF00) -> output = layer 3 value. With no priority layer enabled -> E0E0E0.
- state_i 0 -> 1 with frame_start every 100 cycles, FADE_LOG2 = 4:
  - fade_busy_o rises the next cycle.
  - After 8 pulses, BG channels = 0x70.
  - At pulse 16, level = 0: output 0 and committed_state = 1.
  - After 32 pulses, IDLE with fade_busy_o = 0.
- During FADE_IN at level 10, change state_i to 3 -> next frame_start gives level 9 (FADE_OUT). Assert rst_i mid-fade -> level full, committed_state = 0, outputs 0 for 2 cycles.
- With RGB_COMPOSITOR_COLOR_KEY_EN: layer 3 = FF00FF keyed, layer 4 = 00FF00 enabled, map_enable = 0 -> output 00FF00. Without the macro -> output FF00FF.
